// File: rtl/element_attribute_collector_pkg.sv
// Shared widths, attribute type codes, collector state encodings and
// present-bit indices for the element attribute collector.
package element_attribute_collector_pkg;

  localparam int ATTRIBUTE_TYPE_BITES = 4;
  localparam int ATTRIBUTE_VAL_BITES  = 16;
  localparam int NUM_FIELDS           = 11;
  localparam int PRES_IDX_BITS        = 4;

  typedef logic [ATTRIBUTE_TYPE_BITES-1:0] attr_type_t;
  typedef logic [ATTRIBUTE_VAL_BITES-1:0]  attr_val_t;
  typedef logic [PRES_IDX_BITS-1:0]        pres_idx_t;

  // Attribute type codes produced by attribute_parser; 0 means "no attribute".
  localparam attr_type_t ATT_NONE     = 4'd0;
  localparam attr_type_t ATT_COLOR    = 4'd1;
  localparam attr_type_t ATT_BG       = 4'd2;
  localparam attr_type_t ATT_SIZE     = 4'd3;
  localparam attr_type_t ATT_WIDTH    = 4'd4;
  localparam attr_type_t ATT_HEIGHT   = 4'd5;
  localparam attr_type_t ATT_PADDING  = 4'd6;
  localparam attr_type_t ATT_MARGIN   = 4'd7;
  localparam attr_type_t ATT_BORDER   = 4'd8;
  localparam attr_type_t ATT_POSITION = 4'd9;
  localparam attr_type_t ATT_SRC      = 4'd10;
  localparam attr_type_t ATT_HREF     = 4'd11;

  // Bit positions in out_present (and slot positions in the field record).
  localparam int PRES_COLOR    = 0;
  localparam int PRES_BG       = 1;
  localparam int PRES_SIZE     = 2;
  localparam int PRES_WIDTH    = 3;
  localparam int PRES_HEIGHT   = 4;
  localparam int PRES_PADDING  = 5;
  localparam int PRES_MARGIN   = 6;
  localparam int PRES_BORDER   = 7;
  localparam int PRES_POSITION = 8;
  localparam int PRES_SRC      = 9;
  localparam int PRES_HREF     = 10;

  typedef enum logic [1:0] {
    COL_IDLE    = 2'd0,
    COL_COLLECT = 2'd1,
    COL_PUBLISH = 2'd2
  } col_state_e;

  // True when the type code names one of the record fields.
  function automatic logic att_is_known(input attr_type_t t);
    logic known;
    case (t)
      ATT_COLOR, ATT_BG, ATT_SIZE, ATT_WIDTH, ATT_HEIGHT, ATT_PADDING,
      ATT_MARGIN, ATT_BORDER, ATT_POSITION, ATT_SRC, ATT_HREF: known = 1'b1;
      default:                                                  known = 1'b0;
    endcase
    return known;
  endfunction

  // Map a type code to its record slot; unknown codes map to slot 0 and
  // must be qualified with att_is_known.
  function automatic pres_idx_t att_to_pres(input attr_type_t t);
    pres_idx_t idx;
    case (t)
      ATT_COLOR:    idx = pres_idx_t'(PRES_COLOR);
      ATT_BG:       idx = pres_idx_t'(PRES_BG);
      ATT_SIZE:     idx = pres_idx_t'(PRES_SIZE);
      ATT_WIDTH:    idx = pres_idx_t'(PRES_WIDTH);
      ATT_HEIGHT:   idx = pres_idx_t'(PRES_HEIGHT);
      ATT_PADDING:  idx = pres_idx_t'(PRES_PADDING);
      ATT_MARGIN:   idx = pres_idx_t'(PRES_MARGIN);
      ATT_BORDER:   idx = pres_idx_t'(PRES_BORDER);
      ATT_POSITION: idx = pres_idx_t'(PRES_POSITION);
      ATT_SRC:      idx = pres_idx_t'(PRES_SRC);
      ATT_HREF:     idx = pres_idx_t'(PRES_HREF);
      default:      idx = '0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/element_attribute_collector_edge.sv
// Rising-edge pulse generator. The parser holds its finished level for
// several cycles; only the first cycle of each high phase is an event.
module attr_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_level_q;

  // Remember last cycle's level so a new high phase can be recognised.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level_q <= 1'b0;
    end else begin
      r_level_q <= i_level;
    end
  end

  assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/element_attribute_collector.sv
// Element attribute collector: gathers parsed attributes of one element
// into a style record seeded with defaults, then offers it downstream
// through a valid/ready handshake when the tag closes.
//
// state       | meaning
// ------------+------------------------------------------------------
// COL_IDLE    | no open element; record from last element held
// COL_COLLECT | element open, attributes written into the record
// COL_PUBLISH | record frozen and valid, waiting for out_ready
module element_attribute_collector
  import element_attribute_collector_pkg::*;
#(
  parameter attr_val_t DEF_COLOR    = '0,
  parameter attr_val_t DEF_BG       = '0,
  parameter attr_val_t DEF_SIZE     = attr_val_t'(12),
  parameter attr_val_t DEF_WIDTH    = '0,
  parameter attr_val_t DEF_HEIGHT   = '0,
  parameter attr_val_t DEF_PADDING  = '0,
  parameter attr_val_t DEF_MARGIN   = '0,
  parameter attr_val_t DEF_BORDER   = '0,
  parameter attr_val_t DEF_POSITION = '0
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            elem_start,
  input  logic                            elem_end,
  input  logic                            attr_done,
  input  logic [ATTRIBUTE_TYPE_BITES-1:0] attr_type,
  input  logic [ATTRIBUTE_VAL_BITES-1:0]  attr_value,
  input  logic                            out_ready,
  output logic                            collect_ready,
  output logic                            out_valid,
  output logic [ATTRIBUTE_VAL_BITES-1:0]  out_color,
  output logic [ATTRIBUTE_VAL_BITES-1:0]  out_bg,
  output logic [ATTRIBUTE_VAL_BITES-1:0]  out_size,
  output logic [ATTRIBUTE_VAL_BITES-1:0]  out_width,
  output logic [ATTRIBUTE_VAL_BITES-1:0]  out_height,
  output logic [ATTRIBUTE_VAL_BITES-1:0]  out_padding,
  output logic [ATTRIBUTE_VAL_BITES-1:0]  out_margin,
  output logic [ATTRIBUTE_VAL_BITES-1:0]  out_border,
  output logic [ATTRIBUTE_VAL_BITES-1:0]  out_position,
  output logic [ATTRIBUTE_VAL_BITES-1:0]  out_src,
  output logic [ATTRIBUTE_VAL_BITES-1:0]  out_href,
  output logic [NUM_FIELDS-1:0]           out_present,
  output logic                            out_dup,
  output logic                            out_err
);

  col_state_e                                  r_state;
  logic [NUM_FIELDS-1:0][ATTRIBUTE_VAL_BITES-1:0] r_fields;
  logic [NUM_FIELDS-1:0]                       r_present;
  logic                                        r_dup;
  logic                                        r_err;
  logic                                        r_valid;

  logic [NUM_FIELDS-1:0][ATTRIBUTE_VAL_BITES-1:0] w_defaults;
  logic                                        w_capture;
  logic                                        w_known;
  pres_idx_t                                   w_idx;

  attr_edge_detect u_done_edge (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_level (attr_done),
    .o_rise  (w_capture)
  );

  assign w_defaults[PRES_COLOR]    = DEF_COLOR;
  assign w_defaults[PRES_BG]       = DEF_BG;
  assign w_defaults[PRES_SIZE]     = DEF_SIZE;
  assign w_defaults[PRES_WIDTH]    = DEF_WIDTH;
  assign w_defaults[PRES_HEIGHT]   = DEF_HEIGHT;
  assign w_defaults[PRES_PADDING]  = DEF_PADDING;
  assign w_defaults[PRES_MARGIN]   = DEF_MARGIN;
  assign w_defaults[PRES_BORDER]   = DEF_BORDER;
  assign w_defaults[PRES_POSITION] = DEF_POSITION;
  assign w_defaults[PRES_SRC]      = '0;
  assign w_defaults[PRES_HREF]     = '0;

  assign w_known = att_is_known(attr_type);
  assign w_idx   = att_to_pres(attr_type);

  // Collector FSM: record fields, present/dup/err flags and out_valid all
  // live here. In COLLECT a same-cycle elem_start clears first, and the
  // later field write overrides the cleared slot, so a simultaneous capture
  // lands in the fresh record.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= COL_IDLE;
      r_fields  <= w_defaults;
      r_present <= '0;
      r_dup     <= 1'b0;
      r_err     <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        COL_IDLE: begin
          if (elem_start) begin
            r_fields  <= w_defaults;
            r_present <= '0;
            r_dup     <= 1'b0;
            r_state   <= COL_COLLECT;
          end
        end

        COL_COLLECT: begin
          if (elem_start) begin
            r_fields  <= w_defaults;
            r_present <= '0;
            r_dup     <= 1'b0;
          end
          if (w_capture) begin
            if (w_known) begin
              r_fields[w_idx]  <= attr_value;
              r_present[w_idx] <= 1'b1;
              if (r_present[w_idx] && !elem_start) begin
                r_dup <= 1'b1;
              end
            end else begin
              r_err <= 1'b1;
            end
          end
          if (elem_end && !elem_start) begin
            r_state <= COL_PUBLISH;
            r_valid <= 1'b1;
          end
        end

        COL_PUBLISH: begin
          if (elem_start || elem_end || w_capture) begin
            r_err <= 1'b1;
          end
          if (out_ready) begin
            r_state <= COL_IDLE;
            r_valid <= 1'b0;
          end
        end

        default: begin
          r_state <= COL_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign collect_ready = (r_state != COL_PUBLISH);
  assign out_valid     = r_valid;
  assign out_present   = r_present;
  assign out_dup       = r_dup;
  assign out_err       = r_err;

  assign out_color    = r_fields[PRES_COLOR];
  assign out_bg       = r_fields[PRES_BG];
  assign out_size     = r_fields[PRES_SIZE];
  assign out_width    = r_fields[PRES_WIDTH];
  assign out_height   = r_fields[PRES_HEIGHT];
  assign out_padding  = r_fields[PRES_PADDING];
  assign out_margin   = r_fields[PRES_MARGIN];
  assign out_border   = r_fields[PRES_BORDER];
  assign out_position = r_fields[PRES_POSITION];
  assign out_src      = r_fields[PRES_SRC];
  assign out_href     = r_fields[PRES_HREF];

endmodule

// File: tb/tb_element_attribute_collector.sv
// Bench for element_attribute_collector: directed vector table, hand
// sequences for multi-cycle corners, and random traffic against a
// record-level reference model.
module tb_element_attribute_collector;
  import element_attribute_collector_pkg::*;

  localparam attr_val_t P_DEF_COLOR  = 16'h0A0A;
  localparam attr_val_t P_DEF_BORDER = 16'h0003;

  logic       clock;
  logic       reset_n;
  logic       elem_start, elem_end, attr_done, out_ready;
  attr_type_t attr_type;
  attr_val_t  attr_value;
  logic       collect_ready, out_valid, out_dup, out_err;
  logic [NUM_FIELDS-1:0] out_present;
  attr_val_t  out_color, out_bg, out_size, out_width, out_height, out_padding;
  attr_val_t  out_margin, out_border, out_position, out_src, out_href;

  element_attribute_collector #(
    .DEF_COLOR  (P_DEF_COLOR),
    .DEF_BORDER (P_DEF_BORDER)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .elem_start(elem_start), .elem_end(elem_end),
    .attr_done(attr_done), .attr_type(attr_type), .attr_value(attr_value),
    .out_ready(out_ready), .collect_ready(collect_ready), .out_valid(out_valid),
    .out_color(out_color), .out_bg(out_bg), .out_size(out_size),
    .out_width(out_width), .out_height(out_height), .out_padding(out_padding),
    .out_margin(out_margin), .out_border(out_border), .out_position(out_position),
    .out_src(out_src), .out_href(out_href),
    .out_present(out_present), .out_dup(out_dup), .out_err(out_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  attr_val_t d_f [NUM_FIELDS];
  assign d_f[0]  = out_color;
  assign d_f[1]  = out_bg;
  assign d_f[2]  = out_size;
  assign d_f[3]  = out_width;
  assign d_f[4]  = out_height;
  assign d_f[5]  = out_padding;
  assign d_f[6]  = out_margin;
  assign d_f[7]  = out_border;
  assign d_f[8]  = out_position;
  assign d_f[9]  = out_src;
  assign d_f[10] = out_href;

  int n_vec = 0;
  int n_bad = 0;

  attr_val_t defs [NUM_FIELDS];
  attr_val_t ef   [NUM_FIELDS];

  // Reference model: the record an element would carry.
  attr_val_t m_rec [NUM_FIELDS];
  logic [NUM_FIELDS-1:0] m_pres;
  logic m_dup, m_err, m_open, m_pub, m_prev_done;

  typedef struct {
    logic st, en, dn;
    attr_type_t ty;
    attr_val_t va;
    logic rd;
    logic e_valid, e_cr;
    int e_idx;
    attr_val_t e_fval;
    logic [NUM_FIELDS-1:0] e_pres;
    logic e_dup, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, en, dn, input attr_type_t ty, input attr_val_t va,
                     input logic rd, input logic ev, ecr, input int eidx, input attr_val_t efv,
                     input logic [NUM_FIELDS-1:0] ep, input logic ed, ee);
    vec_t v;
    v.st = st; v.en = en; v.dn = dn; v.ty = ty; v.va = va; v.rd = rd;
    v.e_valid = ev; v.e_cr = ecr; v.e_idx = eidx; v.e_fval = efv;
    v.e_pres = ep; v.e_dup = ed; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic st, en, dn, input attr_type_t ty, input attr_val_t va,
                       input logic rd);
    @(negedge clock);
    elem_start = st; elem_end = en; attr_done = dn;
    attr_type = ty; attr_value = va; out_ready = rd;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_FIELDS; i++) m_rec[i] = defs[i];
    m_pres = '0; m_dup = 0; m_err = 0; m_open = 0; m_pub = 0; m_prev_done = 0;
  endtask

  task automatic model_fresh();
    for (int i = 0; i < NUM_FIELDS; i++) m_rec[i] = defs[i];
    m_pres = '0; m_dup = 0;
  endtask

  // One clock of the model, applied with the inputs present at that edge.
  task automatic model_step(input logic st, en, dn, input attr_type_t ty, input attr_val_t va,
                            input logic rd);
    logic cap;
    int slot;
    cap = dn && !m_prev_done;
    m_prev_done = dn;
    if (m_pub) begin
      if (st || en || cap) m_err = 1;
      if (rd) m_pub = 0;
    end else if (!m_open) begin
      if (st) begin model_fresh(); m_open = 1; end
    end else begin
      if (st) model_fresh();
      if (cap) begin
        if (ty >= 1 && ty <= 11) begin
          slot = int'(ty) - 1;
          if (m_pres[slot]) m_dup = 1;
          m_rec[slot] = va;
          m_pres[slot] = 1;
        end else begin
          m_err = 1;
        end
      end
      if (en && !st) begin m_open = 0; m_pub = 1; end
    end
  endtask

  // Full-record comparison against the expectation held in ef.
  task automatic compare(input string name, input logic ev, ecr,
                         input logic [NUM_FIELDS-1:0] ep, input logic ed, ee);
    int bf;
    int k;
    bf = -1;
    for (int i = 0; i < NUM_FIELDS; i++) if (bf < 0 && d_f[i] !== ef[i]) bf = i;
    n_vec++;
    if (bf >= 0 || out_valid !== ev || collect_ready !== ecr || out_present !== ep ||
        out_dup !== ed || out_err !== ee) begin
      n_bad++;
      k = (bf < 0) ? 0 : bf;
      $display("FAIL %s: got valid=%b rdy=%b pres=%h dup=%b err=%b fld[%0d]=%h ; want valid=%b rdy=%b pres=%h dup=%b err=%b fld[%0d]=%h",
               name, out_valid, collect_ready, out_present, out_dup, out_err, k, d_f[k],
               ev, ecr, ep, ed, ee, k, ef[k]);
    end
  endtask

  task automatic check_model(input string name);
    for (int i = 0; i < NUM_FIELDS; i++) ef[i] = m_rec[i];
    compare(name, m_pub, !m_pub, m_pres, m_dup, m_err);
  endtask

  task automatic set_ef_defaults();
    for (int i = 0; i < NUM_FIELDS; i++) ef[i] = defs[i];
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    elem_start = 0; elem_end = 0; attr_done = 0; attr_type = '0; attr_value = '0; out_ready = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic random_phase(input bit polite, input int cycles);
    logic st, en, dn, rd;
    attr_type_t ty;
    attr_val_t va;
    dn = 0;
    for (int c = 0; c < cycles; c++) begin
      st = ($urandom_range(0, 15) == 0);
      en = ($urandom_range(0, 9) == 0);
      rd = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 2) == 0) dn = ~dn;
      ty = polite ? attr_type_t'($urandom_range(1, 11)) : attr_type_t'($urandom_range(0, 15));
      va = attr_val_t'($urandom);
      if (polite && m_pub) begin st = 0; en = 0; dn = 0; end
      apply(st, en, dn, ty, va, rd);
      model_step(st, en, dn, ty, va, rd);
      check_model(polite ? "rand_polite" : "rand_free");
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_FIELDS; i++) defs[i] = '0;
    defs[PRES_COLOR]  = P_DEF_COLOR;
    defs[PRES_SIZE]   = 16'd12;
    defs[PRES_BORDER] = P_DEF_BORDER;

    // start st en dn ty va rd | valid rdy idx fval pres dup err
    add(1,0,0, ATT_NONE,   0,   0,  0,1, PRES_SIZE,  12,      11'h000,0,0);
    add(0,0,1, ATT_WIDTH,  100, 0,  0,1, PRES_WIDTH, 100,     11'h008,0,0);
    add(0,0,1, ATT_WIDTH,  100, 0,  0,1, PRES_WIDTH, 100,     11'h008,0,0);
    add(0,0,1, ATT_WIDTH,  100, 0,  0,1, PRES_WIDTH, 100,     11'h008,0,0);
    add(0,0,1, ATT_WIDTH,  100, 0,  0,1, PRES_WIDTH, 100,     11'h008,0,0);
    add(0,1,0, ATT_NONE,   0,   1,  1,0, PRES_WIDTH, 100,     11'h008,0,0);
    add(0,0,0, ATT_NONE,   0,   1,  0,1, PRES_SIZE,  12,      11'h008,0,0);
    add(1,0,0, ATT_NONE,   0,   0,  0,1, PRES_WIDTH, 0,       11'h000,0,0);
    add(0,0,1, ATT_COLOR,  5,   0,  0,1, PRES_COLOR, 5,       11'h001,0,0);
    add(0,0,0, ATT_COLOR,  5,   0,  0,1, PRES_COLOR, 5,       11'h001,0,0);
    add(0,0,1, ATT_COLOR,  9,   0,  0,1, PRES_COLOR, 9,       11'h001,1,0);
    add(0,1,0, ATT_NONE,   0,   0,  1,0, PRES_COLOR, 9,       11'h001,1,0);
    add(0,0,0, ATT_NONE,   0,   1,  0,1, PRES_COLOR, 9,       11'h001,1,0);
    add(1,0,0, ATT_NONE,   0,   0,  0,1, PRES_COLOR, 16'h0A0A,11'h000,0,0);
    add(0,0,1, ATT_NONE,   77,  0,  0,1, PRES_COLOR, 16'h0A0A,11'h000,0,1);
    add(0,0,0, ATT_NONE,   0,   0,  0,1, PRES_BORDER,3,       11'h000,0,1);
    add(0,0,1, 4'd13,      5,   0,  0,1, PRES_SIZE,  12,      11'h000,0,1);
    add(0,1,0, ATT_NONE,   0,   0,  1,0, PRES_COLOR, 16'h0A0A,11'h000,0,1);
    add(0,0,0, ATT_NONE,   0,   1,  0,1, PRES_BORDER,3,       11'h000,0,1);

    do_reset();
    set_ef_defaults();
    compare("reset_state", 0, 1, 11'h000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].st, vecs[i].en, vecs[i].dn, vecs[i].ty, vecs[i].va, vecs[i].rd);
      n_vec++;
      if (out_valid !== vecs[i].e_valid || collect_ready !== vecs[i].e_cr ||
          d_f[vecs[i].e_idx] !== vecs[i].e_fval || out_present !== vecs[i].e_pres ||
          out_dup !== vecs[i].e_dup || out_err !== vecs[i].e_err) begin
        n_bad++;
        $display("FAIL vec%0d: got valid=%b rdy=%b fld[%0d]=%h pres=%h dup=%b err=%b ; want valid=%b rdy=%b fld=%h pres=%h dup=%b err=%b",
                 i, out_valid, collect_ready, vecs[i].e_idx, d_f[vecs[i].e_idx], out_present,
                 out_dup, out_err, vecs[i].e_valid, vecs[i].e_cr, vecs[i].e_fval,
                 vecs[i].e_pres, vecs[i].e_dup, vecs[i].e_err);
      end
    end

    // Sticky error is cleared only by reset.
    do_reset();
    set_ef_defaults();
    compare("err_cleared_by_reset", 0, 1, 11'h000, 0, 0);

    // Stalled PUBLISH with elem_start pulses: record frozen, error raised.
    apply(1,0,0, ATT_NONE, 0, 0);
    apply(0,0,1, ATT_HEIGHT, 33, 0);
    apply(0,1,0, ATT_NONE, 0, 0);
    set_ef_defaults();
    ef[PRES_HEIGHT] = 33;
    compare("publish_enter", 1, 0, 11'h010, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply((i % 2) == 0, 0, 0, ATT_NONE, 0, 0);
      compare("publish_stall", 1, 0, 11'h010, 0, 1);
    end
    apply(0,0,0, ATT_NONE, 0, 1);
    compare("publish_release", 0, 1, 11'h010, 0, 1);

    // Capture together with elem_end lands in the published record.
    apply(1,0,0, ATT_NONE, 0, 0);
    apply(0,1,1, ATT_HEIGHT, 7, 0);
    set_ef_defaults();
    ef[PRES_HEIGHT] = 7;
    compare("cap_plus_end", 1, 0, 11'h010, 0, 1);
    apply(0,0,0, ATT_NONE, 0, 1);

    // Capture together with elem_start applies to the fresh record.
    apply(1,0,0, ATT_NONE, 0, 0);
    apply(0,0,1, ATT_WIDTH, 50, 0);
    apply(0,0,0, ATT_NONE, 0, 0);
    apply(1,0,1, ATT_MARGIN, 3, 0);
    set_ef_defaults();
    ef[PRES_MARGIN] = 3;
    compare("cap_plus_start", 0, 1, 11'h040, 0, 1);

    // elem_start wins over elem_end.
    apply(1,1,0, ATT_NONE, 0, 0);
    set_ef_defaults();
    compare("start_plus_end", 0, 1, 11'h000, 0, 1);

    // Asynchronous reset in the middle of PUBLISH.
    apply(0,0,1, ATT_COLOR, 77, 0);
    apply(0,1,0, ATT_NONE, 0, 0);
    ef[PRES_COLOR] = 77;
    compare("pre_async_reset", 1, 0, 11'h001, 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    set_ef_defaults();
    compare("async_reset", 0, 1, 11'h000, 0, 0);

    do_reset();
    random_phase(1'b1, 2000);
    do_reset();
    check_model("reset_before_free");
    random_phase(1'b0, 2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/element_attribute_collector.md
# element_attribute_collector

Collects the stream of parsed attributes for one element into a complete style record. It sits directly downstream of `attribute_parser`, consuming `has_finished`, `out_type` and `out_value`. It starts each element from per-field defaults. On tag close it publishes the record to the layout stage through a valid/ready handshake.

## Interface
Parameters:
- `DEF_COLOR`, 0: colour used when no `color` attribute is seen
- `DEF_BG`, 0: background default
- `DEF_SIZE`, 12: size default
- `DEF_WIDTH`, 0: width default
- `DEF_HEIGHT`, 0: height default
- `DEF_PADDING`, 0: padding default
- `DEF_MARGIN`, 0: margin default
- `DEF_BORDER`, 0: border default
- `DEF_POSITION`, 0: position default
- src and href always default to 0.

Ports:
- `clock`, in, 1: global clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `elem_start`, in, 1: pulse; a new element tag opened.
- `elem_end`, in, 1: pulse; the tag closed, so publish the record.
- `attr_done`, in, 1: the parser's `has_finished` level.
- `attr_type`, in, `ATTRIBUTE_TYPE_BITES`: the parser's `out_type`.
- `attr_value`, in, `ATTRIBUTE_VAL_BITES`: the parser's `out_value`.
- `out_ready`, in, 1: the consumer accepts the record.
- `collect_ready`, out, 1: high when not in PUBLISH. Upstream must not send events while it is low.
- `out_valid`, out, 1: the record is valid.
- `out_color`, `out_bg`, `out_size`, `out_width`, `out_height`, `out_padding`, `out_margin`, `out_border`, `out_position`, `out_src`, `out_href`, out, `ATTRIBUTE_VAL_BITES` each: record fields.
- `out_present`, out, 11: one bit per field, set when the attribute was explicitly given. Bit order follows the list above, color = bit 0.
- `out_dup`, out, 1: some attribute was given more than once in this element.
- `out_err`, out, 1: sticky flag for an unknown type or an event dropped in PUBLISH. Cleared only by reset.

## Operation
- States: IDLE, COLLECT, PUBLISH.
- Capture event: `attr_done & ~attr_done_q`. The parser holds `has_finished` high for several cycles, so only the rising edge counts. `attr_done_q` resets to 0.
- IDLE:
  - `elem_start` loads the defaults, clears `out_present` and `out_dup`, and moves to COLLECT.
  - A capture event or `elem_end` in IDLE is ignored and does not set `out_err`.
- COLLECT, on a capture event:
  - Decode `attr_type` against the `ATT_*` codes and write `attr_value` to the matching field.
  - Set the matching present bit. If that bit was already set, set `out_dup`. The last value written wins.
  - A type code of 0 or any unlisted code writes nothing and sets `out_err`.
- COLLECT, `elem_end`: move to PUBLISH.
- COLLECT, `elem_start`: abort the current element without publishing, reload the defaults and stay in COLLECT.
- PUBLISH:
  - `out_valid` = 1. All fields, `out_present` and `out_dup` are frozen.
  - `out_valid & out_ready`: move to IDLE.
  - Any `elem_start`, `elem_end` or capture event is dropped and sets `out_err`.
- Simultaneous events in COLLECT, same cycle:
  - Capture + `elem_end`: the attribute is written and included in the published record.
  - Capture + `elem_start`: clear to defaults first, then apply the attribute to the fresh record.
  - `elem_start` + `elem_end`: `elem_start` wins; stay in COLLECT with defaults.
- Reset (asynchronous, valid at any point including mid-PUBLISH):
  - State = IDLE.
  - All fields = their defaults, `out_present` = 0.
  - `out_dup`, `out_err`, `out_valid` = 0; `collect_ready` = 1.

## Timing
- Capture event in cycle N: the field is visible at N+1.
- `elem_end` in cycle N: `out_valid` rises at N+1 and `collect_ready` falls at N+1.
- Handshake completes in cycle M: `out_valid` = 0 and `collect_ready` = 1 at M+1. A new `elem_start` is legal in cycle M+1.
- `out_valid` never drops without `out_ready`.
- All outputs are registered; `collect_ready` is decoded from state only.

## Structure
- The `ATT_*` codes and the `ATTRIBUTE_TYPE_BITES` / `ATTRIBUTE_VAL_BITES` widths stay in the shared `constants.v`.
- Add the state encodings `COL_IDLE`, `COL_COLLECT` and `COL_PUBLISH` there.
- Add the `out_present` bit indices `PRES_COLOR` … `PRES_HREF` there as well.
- One sub-module: `attr_edge_detect`, the rising-edge pulse generator on `attr_done`. It is reusable for the tag parser's enables.

## Test plan
- Reset, `elem_start`, `width`=100 (done held for 4 cycles), `elem_end`, `out_ready`=1 → exactly one write. Record has width=100, size=12 and `out_present`=only WIDTH. `out_valid` lasts 1 cycle.
- `elem_start`, `color`=5, `color`=9, `elem_end` → color=9, `out_dup`=1, `out_err`=0.
- Unknown type code 0 captured during COLLECT → no field changes, `out_err`=1. `out_err` persists until `reset_n` is asserted.
- PUBLISH with `out_ready`=0 for 5 cycles while `elem_start` pulses → `out_valid` and the fields stay stable, `out_err`=1. Raising `out_ready` returns to IDLE next cycle.
- Same-cycle capture (`height`=7) + `elem_end` → published height=7. Same-cycle capture (`margin`=3) + `elem_start` → new record has margin=3 and all other fields at defaults.
- `reset_n` low mid-PUBLISH → `out_valid`=0 immediately (asynchronously), all fields at defaults, `collect_ready`=1.
